// File: rtl/fetch_unit.sv
// Y86-64 fetch stage: byte-serial instruction fetch, length decode and field assembly.
// Optional counters are enabled by defining FETCH_STAT_EN.
//
// state | meaning
// IDLE  | waiting for a PC load
// FETCH | issuing byte reads, imem_req_o high
// DONE  | decoded instruction presented, held until instr_ready_i
module fetch_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [63:0] pc_i,
  input  logic        pc_load_i,
  output logic        pc_ready_o,
  output logic        imem_req_o,
  output logic [63:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [7:0]  imem_rdata_i,
  input  logic        imem_err_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [3:0]  icode_o,
  output logic [3:0]  ifun_o,
  output logic [3:0]  rA_o,
  output logic [3:0]  rB_o,
  output logic [63:0] valC_o,
  output logic [63:0] valP_o,
  output logic        instr_invalid_o,
  output logic        imem_error_o,
  output logic        busy_o,
  output logic [31:0] stat_instr_o,
  output logic [31:0] stat_wait_o
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, addr_q, valc_q, valp_q;
  logic [3:0]  cnt_q, len_q, icode_q, ifun_q, ra_q, rb_q;
  logic        inv_q, err_q;
  logic        load_acc, ack_acc, last_byte, abort, tmo_hit;
  logic [3:0]  len_cur;
  logic [2:0]  cbyte;

  function automatic logic [3:0] ilen(input logic [3:0] ic);
    case (ic)
      4'h2, 4'h6, 4'hA, 4'hB: ilen = 4'd2;
      4'h3, 4'h4, 4'h5:       ilen = 4'd10;
      4'h7, 4'h8:             ilen = 4'd9;
      default:                ilen = 4'd1;
    endcase
  endfunction

  assign pc_ready_o = (state_q == S_IDLE) || (state_q == S_DONE && instr_ready_i);
  assign load_acc   = pc_load_i && pc_ready_o;
  assign ack_acc    = (state_q == S_FETCH) && imem_ack_i;
  assign len_cur    = (cnt_q == 4'd0) ? ilen(imem_rdata_i[7:4]) : len_q;
  assign last_byte  = ack_acc && !imem_err_i && (cnt_q + 4'd1 == len_cur);
  assign abort      = (ack_acc && imem_err_i) || tmo_hit;
  // constant bytes start at offset 2 for 10-byte forms, offset 1 for 9-byte forms
  assign cbyte      = (len_q == 4'd10) ? 3'(cnt_q - 4'd2) : 3'(cnt_q - 4'd1);

  generate
    if (TIMEOUT == 0) begin : g_no_tmo
      assign tmo_hit = 1'b0;
    end else begin : g_tmo
      localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
      logic [TW-1:0] tmr_q;
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)                tmr_q <= '0;
        else if (load_acc || ack_acc) tmr_q <= TW'(TIMEOUT - 1);
        else if (state_q == S_FETCH && tmr_q != '0) tmr_q <= tmr_q - 1'b1;
      end
      assign tmo_hit = (state_q == S_FETCH) && !imem_ack_i && (tmr_q == '0);
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (load_acc) state_d = S_FETCH;
      S_FETCH: if (last_byte || abort) state_d = S_DONE;
      S_DONE:  if (instr_ready_i) state_d = load_acc ? S_FETCH : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pc_q    <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      len_q   <= 4'd1;
      icode_q <= '0;
      ifun_q  <= '0;
      ra_q    <= 4'hF;
      rb_q    <= 4'hF;
      valc_q  <= '0;
      valp_q  <= '0;
      inv_q   <= 1'b0;
      err_q   <= 1'b0;
    end else if (load_acc) begin
      pc_q    <= pc_i;
      addr_q  <= pc_i;
      cnt_q   <= '0;
      len_q   <= 4'd1;
      icode_q <= '0;
      ifun_q  <= '0;
      ra_q    <= 4'hF;
      rb_q    <= 4'hF;
      valc_q  <= '0;
      valp_q  <= '0;
      inv_q   <= 1'b0;
      err_q   <= 1'b0;
    end else if (state_q == S_FETCH) begin
      if (abort) begin
        err_q  <= 1'b1;
        valp_q <= pc_q + 64'(cnt_q);
      end else if (ack_acc) begin
        cnt_q <= cnt_q + 4'd1;
        if (cnt_q == 4'd0) begin
          icode_q <= imem_rdata_i[7:4];
          ifun_q  <= imem_rdata_i[3:0];
          len_q   <= len_cur;
          inv_q   <= imem_rdata_i[7:4] > 4'hB;
        end else if (cnt_q == 4'd1 && (len_q == 4'd2 || len_q == 4'd10)) begin
          ra_q <= imem_rdata_i[7:4];
          rb_q <= imem_rdata_i[3:0];
        end else begin
          valc_q[{cbyte, 3'b000} +: 8] <= imem_rdata_i;
        end
        if (last_byte) valp_q <= pc_q + 64'(len_cur);
        else           addr_q <= addr_q + 64'd1;
      end
    end
  end

  assign imem_req_o      = (state_q == S_FETCH);
  assign busy_o          = (state_q == S_FETCH);
  assign instr_valid_o   = (state_q == S_DONE);
  assign imem_addr_o     = addr_q;
  assign icode_o         = icode_q;
  assign ifun_o          = ifun_q;
  assign rA_o            = ra_q;
  assign rB_o            = rb_q;
  assign valC_o          = valc_q;
  assign valP_o          = valp_q;
  assign instr_invalid_o = inv_q;
  assign imem_error_o    = err_q;

`ifdef FETCH_STAT_EN
  logic [31:0] st_instr_q, st_wait_q;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      st_instr_q <= '0;
      st_wait_q  <= '0;
    end else begin
      if (instr_valid_o && instr_ready_i) st_instr_q <= st_instr_q + 32'd1;
      if (imem_req_o && !imem_ack_i)      st_wait_q  <= st_wait_q + 32'd1;
    end
  end
  assign stat_instr_o = st_instr_q;
  assign stat_wait_o  = st_wait_q;
`else
  assign stat_instr_o = '0;
  assign stat_wait_o  = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: memory responder with random waits/errors and a
// byte-level reference model of the Y86-64 length and field rules.
module tb_fetch_unit;
  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [63:0] pc_i;
  logic        pc_load_i;
  logic        pc_ready_o;
  logic        imem_req_o;
  logic [63:0] imem_addr_o;
  logic        imem_ack_i;
  logic [7:0]  imem_rdata_i;
  logic        imem_err_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [3:0]  icode_o, ifun_o, rA_o, rB_o;
  logic [63:0] valC_o, valP_o;
  logic        instr_invalid_o, imem_error_o, busy_o;
  logic [31:0] stat_instr_o, stat_wait_o;

  localparam int TMO = 16;

  fetch_unit #(.TIMEOUT(TMO)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .pc_i(pc_i), .pc_load_i(pc_load_i),
    .pc_ready_o(pc_ready_o), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i), .imem_err_i(imem_err_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .icode_o(icode_o), .ifun_o(ifun_o), .rA_o(rA_o), .rB_o(rB_o),
    .valC_o(valC_o), .valP_o(valP_o), .instr_invalid_o(instr_invalid_o),
    .imem_error_o(imem_error_o), .busy_o(busy_o),
    .stat_instr_o(stat_instr_o), .stat_wait_o(stat_wait_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errs   = 0;
  logic [7:0] mem_b [10];
  int  exp_wait  = 0;
  int  exp_instr = 0;
  bit  pending   = 0;

  logic [3:0]  e_icode, e_ifun, e_ra, e_rb;
  logic [63:0] e_c, e_p;
  logic        e_inv, e_err;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int model_len(input logic [3:0] ic);
    if (ic == 4'h0 || ic == 4'h1 || ic == 4'h9) return 1;
    if (ic == 4'h2 || ic == 4'h6 || ic == 4'hA || ic == 4'hB) return 2;
    if (ic >= 4'h3 && ic <= 4'h5) return 10;
    if (ic == 4'h7 || ic == 4'h8) return 9;
    return 1;
  endfunction

  task automatic check_stats(input string tag);
`ifdef FETCH_STAT_EN
    check_val({tag, " stat_wait"}, 64'(stat_wait_o), 64'(exp_wait));
    check_val({tag, " stat_instr"}, 64'(stat_instr_o), 64'(exp_instr));
`else
    check_val({tag, " stat_wait"}, 64'(stat_wait_o), 64'd0);
    check_val({tag, " stat_instr"}, 64'(stat_instr_o), 64'd0);
`endif
  endtask

  task automatic check_fields(input string tag);
    check_val({tag, " valid"}, 64'(instr_valid_o), 64'd1);
    check_val({tag, " req"}, 64'(imem_req_o), 64'd0);
    check_val({tag, " icode"}, 64'(icode_o), 64'(e_icode));
    check_val({tag, " ifun"}, 64'(ifun_o), 64'(e_ifun));
    check_val({tag, " rA"}, 64'(rA_o), 64'(e_ra));
    check_val({tag, " rB"}, 64'(rB_o), 64'(e_rb));
    check_val({tag, " valC"}, valC_o, e_c);
    check_val({tag, " valP"}, valP_o, e_p);
    check_val({tag, " invalid"}, 64'(instr_invalid_o), 64'(e_inv));
    check_val({tag, " error"}, 64'(imem_error_o), 64'(e_err));
  endtask

  // Loads pc, serves mem_b with random wait states (optional error at byte err_at,
  // or no ack at all), then compares the presented instruction with the model.
  task automatic run_fetch(input logic [63:0] pc, input int max_wait, input int err_at,
                           input bit no_ack, input string tag);
    int n, wl, cyc, waits, len, nrecv, cbase;
    @(negedge clk_i);
    pc_i = pc; pc_load_i = 1'b1; instr_ready_i = 1'b1;
    #1;
    check_val({tag, " pc_ready"}, 64'(pc_ready_o), 64'd1);
    if (pending) exp_instr++;
    pending = 1'b0;
    @(negedge clk_i);
    pc_load_i = 1'b0; instr_ready_i = 1'b0; pc_i = {$urandom, $urandom};
    n = 0; cyc = 0; waits = 0;
    wl = $urandom_range(max_wait, 0);
    while (imem_req_o && cyc < 100) begin
      check_val({tag, " addr"}, imem_addr_o, pc + 64'(n));
      if (!no_ack && wl == 0 && n < 10) begin
        imem_ack_i = 1'b1; imem_rdata_i = mem_b[n]; imem_err_i = (n == err_at);
        n++;
        wl = $urandom_range(max_wait, 0);
      end else begin
        imem_ack_i = 1'b0; imem_rdata_i = 8'($urandom); imem_err_i = 1'($urandom);
        if (wl > 0) wl--;
        waits++; exp_wait++;
      end
      cyc++;
      @(negedge clk_i);
      imem_ack_i = 1'b0; imem_err_i = 1'b0;
    end
    check_val({tag, " fetch bound"}, 64'(cyc < 100), 64'd1);

    len = model_len(mem_b[0][7:4]);
    if (no_ack)            nrecv = 0;
    else if (err_at < len) nrecv = err_at;
    else                   nrecv = len;
    e_err   = no_ack || (err_at < len);
    e_icode = (nrecv >= 1) ? mem_b[0][7:4] : 4'h0;
    e_ifun  = (nrecv >= 1) ? mem_b[0][3:0] : 4'h0;
    e_inv   = (nrecv >= 1) && (mem_b[0][7:4] > 4'hB);
    e_ra    = (nrecv >= 2 && (len == 2 || len == 10)) ? mem_b[1][7:4] : 4'hF;
    e_rb    = (nrecv >= 2 && (len == 2 || len == 10)) ? mem_b[1][3:0] : 4'hF;
    cbase   = (len == 10) ? 2 : ((len == 9) ? 1 : 10);
    e_c     = '0;
    for (int k = 0; k < 8; k++)
      if (cbase + k < nrecv) e_c[8*k +: 8] = mem_b[cbase + k];
    e_p = pc + 64'(nrecv);

    check_val({tag, " acks"}, 64'(n), 64'(no_ack ? 0 : (e_err ? nrecv + 1 : nrecv)));
    check_val({tag, " latency"}, 64'(cyc), 64'(no_ack ? TMO : n + waits));
    check_fields(tag);
    check_val({tag, " busy"}, 64'(busy_o), 64'd0);
    check_stats(tag);
    pending = 1'b1;
  endtask

  // Holds instr_ready_i low with loads and stray acks offered; nothing may change.
  task automatic hold_check(input int cycles, input string tag);
    for (int i = 0; i < cycles; i++) begin
      instr_ready_i = 1'b0; pc_load_i = 1'b1; pc_i = {$urandom, $urandom};
      imem_ack_i = 1'($urandom); imem_rdata_i = 8'($urandom); imem_err_i = 1'($urandom);
      #1;
      check_val({tag, " hold pc_ready"}, 64'(pc_ready_o), 64'd0);
      @(negedge clk_i);
      check_fields({tag, " hold"});
    end
    pc_load_i = 1'b0; imem_ack_i = 1'b0; imem_err_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, err_at;
    rst_n_i = 1'b0; pc_i = '0; pc_load_i = 1'b0; imem_ack_i = 1'b0;
    imem_rdata_i = '0; imem_err_i = 1'b0; instr_ready_i = 1'b0;
    #12;
    check_val("reset valid", 64'(instr_valid_o), 64'd0);
    check_val("reset req", 64'(imem_req_o), 64'd0);
    check_val("reset rA", 64'(rA_o), 64'hF);
    check_val("reset rB", 64'(rB_o), 64'hF);
    check_val("reset valC", valC_o, 64'd0);
    check_val("reset valP", valP_o, 64'd0);
    check_val("reset error", 64'(imem_error_o), 64'd0);
    check_val("reset pc_ready", 64'(pc_ready_o), 64'd1);
    check_stats("reset");
    @(negedge clk_i);
    rst_n_i = 1'b1;

    mem_b[0] = 8'h10;
    run_fetch(64'h100, 0, 99, 1'b0, "nop");

    mem_b[0] = 8'h30; mem_b[1] = 8'hF3;
    for (int k = 0; k < 8; k++) mem_b[2+k] = 8'(k + 1);
    run_fetch(64'h200, 0, 99, 1'b0, "irmovq");
    check_val("irmovq valC const", valC_o, 64'h0807060504030201);

    mem_b[0] = 8'h74;
    for (int k = 1; k < 10; k++) mem_b[k] = 8'($urandom);
    run_fetch(64'hFFFF_FFFF_FFFF_FFFC, 3, 99, 1'b0, "jxx wrap");

    mem_b[0] = 8'hC0;
    run_fetch(64'h4000, 2, 99, 1'b0, "invalid");
    hold_check(5, "invalid");

    run_fetch(64'h5000, 0, 99, 1'b1, "timeout");

    mem_b[0] = 8'h40; mem_b[1] = 8'h12;
    for (int k = 2; k < 10; k++) mem_b[k] = 8'($urandom);
    run_fetch(64'h6000, 1, 2, 1'b0, "rmmovq err");

    // reset in the middle of an irmovq after four bytes
    mem_b[0] = 8'h30; mem_b[1] = 8'hF7;
    for (int k = 2; k < 10; k++) mem_b[k] = 8'($urandom);
    @(negedge clk_i);
    pc_i = 64'h280; pc_load_i = 1'b1; instr_ready_i = 1'b1;
    @(negedge clk_i);
    pc_load_i = 1'b0; instr_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      imem_ack_i = 1'b1; imem_rdata_i = mem_b[k];
      @(negedge clk_i);
    end
    imem_ack_i = 1'b0;
    #2 rst_n_i = 1'b0;
    #1;
    check_val("midreset req", 64'(imem_req_o), 64'd0);
    check_val("midreset valid", 64'(instr_valid_o), 64'd0);
    check_val("midreset valC", valC_o, 64'd0);
    check_val("midreset rB", 64'(rB_o), 64'hF);
    exp_wait = 0; exp_instr = 0; pending = 1'b0;
    check_stats("midreset");
    @(negedge clk_i);
    rst_n_i = 1'b1;
    mem_b[0] = 8'h30; mem_b[1] = 8'hF5;
    for (int k = 2; k < 10; k++) mem_b[k] = 8'($urandom);
    run_fetch(64'h300, 0, 99, 1'b0, "post reset");

    for (int it = 0; it < 25; it++) begin
      for (int k = 0; k < 10; k++) mem_b[k] = 8'($urandom);
      len = model_len(mem_b[0][7:4]);
      err_at = ($urandom_range(3, 0) == 0) ? int'($urandom_range(len - 1, 0)) : 99;
      run_fetch({$urandom, $urandom}, $urandom_range(3, 0), err_at, 1'b0, "random");
      hold_check($urandom_range(2, 0), "random");
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
